// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-drain UART transmitter.
//   utx_state_e      : transmitter FSM states (also exported as a debug port)
//   DEF_*            : default parameter values for the transmitter
//   FRAME_BITS       : line bits per frame at the default settings (no parity)
//   DEF_BAUD_W/BIT_W : counter widths derived from the defaults
package utx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        WAIT,
        START,
        DATA,
        PARITY,
        STOP
    } utx_state_e;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_PARITY_EN    = 0;

    // start + data + optional parity + stop
    localparam int FRAME_BITS = 2 + DEF_DATA_W + DEF_PARITY_EN;

    localparam int DEF_BAUD_W = $clog2(DEF_CLKS_PER_BIT);
    localparam int DEF_BIT_W  = $clog2(DEF_DATA_W + 1);

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the FIFO and its drain stage.
//   utx_fifo_empty_i : FIFO empty flag          (FIFO -> drain)
//   utx_fifo_data_i  : FIFO read data           (FIFO -> drain), valid the
//                      cycle after the FIFO samples rd_en
//   utx_fifo_rd_en_o : pop request              (drain -> FIFO)
// Handshake: the drain pops only when it has seen empty low; the FIFO
// samples rd_en on a rising edge and presents the popped word on the next
// cycle. There is no back-pressure from the FIFO side.
// master = drain stage (read-side master), slave = FIFO.
interface fifo_uart_tx_if #(
    parameter int DATA_W = 8
);
    logic              utx_fifo_empty_i;
    logic [DATA_W-1:0] utx_fifo_data_i;
    logic              utx_fifo_rd_en_o;

    modport master (
        input  utx_fifo_empty_i,
        input  utx_fifo_data_i,
        output utx_fifo_rd_en_o
    );

    modport slave (
        output utx_fifo_empty_i,
        output utx_fifo_data_i,
        input  utx_fifo_rd_en_o
    );
endinterface

// File: rtl/fifo_uart_tx_baud_cnt.sv
// Bit-period counter for the UART transmitter.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   clr_i  : synchronous clear (restarts the bit period)
//   tick_o : high on the last cycle of each CLKS_PER_BIT period
module utx_baud_cnt #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO onto a UART-style serial line.
// Frame: start(0), DATA_W bits LSB-first, optional even parity, stop(1).
//   utx_clk_i   : clock, rising edge
//   utx_rst_i   : asynchronous active-high reset
//   utx_en_i    : transmit enable, only looked at in IDLE
//   fifo_if     : FIFO read port (master side: empty/data in, rd_en out)
//   utx_txd_o   : serial line, idles high, registered
//   utx_busy_o  : high outside IDLE
//   utx_done_o  : one-cycle pulse on the last cycle of the stop bit
//   utx_state_o : current FSM state (debug)
module fifo_uart_tx
    import utx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int PARITY_EN    = DEF_PARITY_EN
) (
    input  logic          utx_clk_i,
    input  logic          utx_rst_i,
    input  logic          utx_en_i,
    fifo_uart_tx_if.master fifo_if,
    output logic          utx_txd_o,
    output logic          utx_busy_o,
    output logic          utx_done_o,
    output utx_state_e    utx_state_o
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_W + 1);

    utx_state_e        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              parity_q, parity_d;
    logic              txd_q, txd_d;
    logic              rd_en_q, rd_en_d;
    logic              bit_tick;
    logic              baud_clr;

    // Restart the bit period on every state change so each timed state
    // lasts exactly CLKS_PER_BIT cycles from its first cycle.
    assign baud_clr = (state_d != state_q);

    utx_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (BAUD_W)
    ) u_baud (
        .clk_i  (utx_clk_i),
        .rst_i  (utx_rst_i),
        .clr_i  (baud_clr),
        .tick_o (bit_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        case (state_q)
            IDLE: begin
                if (utx_en_i && !fifo_if.utx_fifo_empty_i) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = WAIT;
            end
            WAIT: begin
                // FIFO presents the popped word in this cycle.
                shift_d   = fifo_if.utx_fifo_data_i;
                parity_d  = ^fifo_if.utx_fifo_data_i;
                bit_cnt_d = '0;
                state_d   = START;
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level and pop strobe are registered from the next state so they
    // line up with state_q and never glitch.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            PARITY:  txd_d = parity_d;
            default: txd_d = 1'b1;
        endcase
        rd_en_d = (state_d == POP);
    end

    always_ff @(posedge utx_clk_i or posedge utx_rst_i) begin
        if (utx_rst_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            txd_q     <= 1'b1;
            rd_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            txd_q     <= txd_d;
            rd_en_q   <= rd_en_d;
        end
    end

    assign fifo_if.utx_fifo_rd_en_o = rd_en_q;
    assign utx_txd_o   = txd_q;
    assign utx_busy_o  = (state_q != IDLE);
    assign utx_done_o  = (state_q == STOP) && bit_tick;
    assign utx_state_o = state_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (no parity / even parity) at
// CLKS_PER_BIT=4, each fed by a small FIFO model, plus a line decoder on
// the no-parity instance.
module tb_fifo_uart_tx;
    import utx_pkg::*;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en0 = 1'b0;
    logic en1 = 1'b0;

    always #5 clk = ~clk;

    fifo_uart_tx_if #(.DATA_W(8)) if0 ();
    fifo_uart_tx_if #(.DATA_W(8)) if1 ();

    logic       txd0, busy0, done0, txd1, busy1, done1;
    utx_state_e st0, st1;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(0)) u_dut0 (
        .utx_clk_i   (clk),
        .utx_rst_i   (rst),
        .utx_en_i    (en0),
        .fifo_if     (if0.master),
        .utx_txd_o   (txd0),
        .utx_busy_o  (busy0),
        .utx_done_o  (done0),
        .utx_state_o (st0)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(1)) u_dut1 (
        .utx_clk_i   (clk),
        .utx_rst_i   (rst),
        .utx_en_i    (en1),
        .fifo_if     (if1.master),
        .utx_txd_o   (txd1),
        .utx_busy_o  (busy1),
        .utx_done_o  (done1),
        .utx_state_o (st1)
    );

    // ---------------- FIFO models (not reset by the DUT reset) ----------
    logic [7:0] fq0[$];
    logic [7:0] fq1[$];
    logic       wr0 = 1'b0, wr1 = 1'b0;
    logic [7:0] wd0 = '0, wd1 = '0;
    logic       empty0 = 1'b1, empty1 = 1'b1;
    logic [7:0] rdata0 = '0, rdata1 = '0;
    int         underrun0 = 0, underrun1 = 0;

    assign if0.utx_fifo_empty_i = empty0;
    assign if0.utx_fifo_data_i  = rdata0;
    assign if1.utx_fifo_empty_i = empty1;
    assign if1.utx_fifo_data_i  = rdata1;

    always @(posedge clk) begin
        if (if0.utx_fifo_rd_en_o) begin
            if (fq0.size() > 0) rdata0 <= fq0.pop_front();
            else underrun0 <= underrun0 + 1;
        end
        if (wr0) fq0.push_back(wd0);
        empty0 <= (fq0.size() == 0);
    end

    always @(posedge clk) begin
        if (if1.utx_fifo_rd_en_o) begin
            if (fq1.size() > 0) rdata1 <= fq1.pop_front();
            else underrun1 <= underrun1 + 1;
        end
        if (wr1) fq1.push_back(wd1);
        empty1 <= (fq1.size() == 0);
    end

    // ---------------- pulse counters ----------------
    int rd_cnt0 = 0, rd_cnt1 = 0, done_cnt0 = 0, done_cnt1 = 0;
    always @(negedge clk) begin
        if (if0.utx_fifo_rd_en_o) rd_cnt0 <= rd_cnt0 + 1;
        if (if1.utx_fifo_rd_en_o) rd_cnt1 <= rd_cnt1 + 1;
        if (done0) done_cnt0 <= done_cnt0 + 1;
        if (done1) done_cnt1 <= done_cnt1 + 1;
    end

    // ---------------- line decoder for instance 0 ----------------
    logic [7:0] rx_q0[$];
    logic       dec_active = 1'b0;
    int         dec_cnt = 0;
    int         gap = 0;
    int         min_gap = 1000;
    int         frames0 = 0;
    int         stop_err0 = 0;
    logic [7:0] dec_sh = '0;

    always @(negedge clk) begin
        if (rst) begin
            dec_active = 1'b0;
            gap = 0;
        end else if (!dec_active) begin
            if (txd0 == 1'b0) begin
                dec_active = 1'b1;
                dec_cnt = 0;
                if (frames0 > 0 && gap < min_gap) min_gap = gap;
                gap = 0;
            end else begin
                gap = gap + 1;
            end
        end else begin
            dec_cnt = dec_cnt + 1;
            if ((dec_cnt % CPB) == 2 && dec_cnt >= 6 && dec_cnt <= 34)
                dec_sh[(dec_cnt - 6) / CPB] = txd0;
            if (dec_cnt == 38) begin
                if (txd0) rx_q0.push_back(dec_sh);
                else stop_err0 = stop_err0 + 1;
                frames0 = frames0 + 1;
            end
            if (dec_cnt == 39) dec_active = 1'b0;
        end
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic txd_of(input int d);
        return (d != 0) ? txd1 : txd0;
    endfunction
    function automatic logic rd_of(input int d);
        return (d != 0) ? if1.utx_fifo_rd_en_o : if0.utx_fifo_rd_en_o;
    endfunction
    function automatic logic done_of(input int d);
        return (d != 0) ? done1 : done0;
    endfunction
    function automatic logic busy_of(input int d);
        return (d != 0) ? busy1 : busy0;
    endfunction

    task automatic fifo_push(input int d, input logic [7:0] b);
        @(negedge clk);
        if (d != 0) begin wr1 = 1'b1; wd1 = b; end
        else begin wr0 = 1'b1; wd0 = b; end
        @(posedge clk);
        #1;
        wr0 = 1'b0;
        wr1 = 1'b0;
    endtask

    task automatic set_en(input int d, input logic v);
        if (d != 0) en1 = v;
        else en0 = v;
    endtask

    // Pushes one byte, enables, and checks every line cycle of the frame
    // against exp_bits (exp_bits[i] = i-th bit on the line).
    task automatic check_frame(input int d, input logic [7:0] b,
                               input logic [10:0] exp_bits, input int nbits,
                               input string name);
        int rd_base, done_base, t;
        int empty_now;
        rd_base   = (d != 0) ? rd_cnt1 : rd_cnt0;
        done_base = (d != 0) ? done_cnt1 : done_cnt0;
        fifo_push(d, b);
        @(negedge clk);
        set_en(d, 1'b1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!rd_of(d) && t < 20);
        n_checks++;
        if (rd_of(d) !== 1'b1) begin
            $display("FAIL %s_pop_timeout: rd_en=%b after %0d cycles, required 1", name, rd_of(d), t);
            set_en(d, 1'b0);
            return;
        end
        n_pass++;
        n_checks++;
        if (t !== 1) $display("FAIL %s_pop_latency: %0d cycles, required 1", name, t);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (txd_of(d) !== 1'b1) $display("FAIL %s_wait_txd: got %b, required 1", name, txd_of(d));
        else n_pass++;
        for (int c = 0; c < nbits * CPB; c++) begin
            @(negedge clk);
            n_checks++;
            if (txd_of(d) !== exp_bits[c / CPB])
                $display("FAIL %s_txd cycle %0d: got %b, required %b", name, c, txd_of(d), exp_bits[c / CPB]);
            else n_pass++;
            n_checks++;
            if (done_of(d) !== (c == nbits * CPB - 1))
                $display("FAIL %s_done cycle %0d: got %b, required %b", name, c, done_of(d), (c == nbits * CPB - 1));
            else n_pass++;
        end
        @(negedge clk);
        set_en(d, 1'b0);
        n_checks++;
        if (busy_of(d) !== 1'b0) $display("FAIL %s_busy_after: got %b, required 0", name, busy_of(d));
        else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++;
        if (((d != 0) ? rd_cnt1 : rd_cnt0) - rd_base !== 1)
            $display("FAIL %s_rd_pulses: got %0d, required 1", name, ((d != 0) ? rd_cnt1 : rd_cnt0) - rd_base);
        else n_pass++;
        n_checks++;
        if (((d != 0) ? done_cnt1 : done_cnt0) - done_base !== 1)
            $display("FAIL %s_done_pulses: got %0d, required 1", name, ((d != 0) ? done_cnt1 : done_cnt0) - done_base);
        else n_pass++;
        empty_now = (d != 0) ? int'(empty1) : int'(empty0);
        n_checks++;
        if (empty_now !== 1) $display("FAIL %s_fifo_empty: got %0d, required 1", name, empty_now);
        else n_pass++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        int rxb, t;
        rxb = rx_q0.size();
        en0 = 1'b1;
        fifo_push(0, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if ({txd0, if0.utx_fifo_rd_en_o, busy0, done0} !== 4'b1000)
                $display("FAIL reset_outputs cycle %0d: got %b, required 1000", i, {txd0, if0.utx_fifo_rd_en_o, busy0, done0});
            else n_pass++;
            n_checks++;
            if (st0 !== IDLE) $display("FAIL reset_state: got %0d, required %0d", st0, IDLE);
            else n_pass++;
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (if0.utx_fifo_rd_en_o !== 1'b0) $display("FAIL reset_release_rd: got %b, required 0", if0.utx_fifo_rd_en_o);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (if0.utx_fifo_rd_en_o !== 1'b1) $display("FAIL reset_first_pop: got %b, required 1", if0.utx_fifo_rd_en_o);
        else n_pass++;
        t = 0;
        while (rx_q0.size() == rxb && t < 80) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (rx_q0.size() != rxb + 1) $display("FAIL reset_frame_timeout: frames=%0d, required 1", rx_q0.size() - rxb);
        else if (rx_q0[rxb] !== 8'hA5) $display("FAIL reset_frame_byte: got %h, required a5", rx_q0[rxb]);
        else n_pass++;
        en0 = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_single_byte;
        // 0x64 on the line: 0 | 0,0,1,0,0,1,1,0 | 1
        check_frame(0, 8'h64, {1'b0, 10'b1011001000}, 10, "byte64");
    endtask

    task automatic test_empty_idle;
        en0 = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n_checks++;
            if ({txd0, if0.utx_fifo_rd_en_o, busy0} !== 3'b100)
                $display("FAIL empty_idle cycle %0d: txd/rd/busy=%b, required 100", i, {txd0, if0.utx_fifo_rd_en_o, busy0});
            else n_pass++;
        end
        en0 = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int rxb, rd_base, t;
        rxb = rx_q0.size();
        rd_base = rd_cnt0;
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            fifo_push(0, b);
        end
        @(negedge clk);
        en0 = 1'b1;
        t = 0;
        while (rx_q0.size() - rxb < 16 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        repeat (20) @(negedge clk);
        en0 = 1'b0;
        n_checks++;
        if (rx_q0.size() - rxb !== 16) $display("FAIL b2b_frame_count: got %0d, required 16", rx_q0.size() - rxb);
        else n_pass++;
        for (int i = 0; i < 16 && rxb + i < rx_q0.size(); i++) begin
            b = exp_q.pop_front();
            n_checks++;
            if (rx_q0[rxb + i] !== b) $display("FAIL b2b_byte %0d: got %h, required %h", i, rx_q0[rxb + i], b);
            else n_pass++;
        end
        n_checks++;
        if (rd_cnt0 - rd_base !== 16) $display("FAIL b2b_rd_pulses: got %0d, required 16", rd_cnt0 - rd_base);
        else n_pass++;
        n_checks++;
        if (empty0 !== 1'b1) $display("FAIL b2b_fifo_empty: got %b, required 1", empty0);
        else n_pass++;
        n_checks++;
        if (min_gap < 3) $display("FAIL b2b_min_gap: got %0d, required >= 3", min_gap);
        else n_pass++;
        n_checks++;
        if (stop_err0 !== 0 || underrun0 !== 0)
            $display("FAIL b2b_stop_underrun: stop_err=%0d underrun=%0d, required 0 0", stop_err0, underrun0);
        else n_pass++;
    endtask

    task automatic test_parity;
        // 0x07: three ones -> parity 1, 11-bit frame
        check_frame(1, 8'h07, 11'b11000001110, 11, "par07");
        // 0x03: two ones -> parity 0
        check_frame(1, 8'h03, 11'b10000000110, 11, "par03");
    endtask

    task automatic test_reset_midframe;
        int rxb, rd_base, t;
        rxb = rx_q0.size();
        rd_base = rd_cnt0;
        fifo_push(0, 8'hA5);
        fifo_push(0, 8'h3C);
        @(negedge clk);
        en0 = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!if0.utx_fifo_rd_en_o && t < 20);
        // POP here; data bit 3 occupies cycles 18..21 after POP
        repeat (19) @(negedge clk);
        n_checks++;
        if (txd0 !== 1'b0 || st0 !== DATA)
            $display("FAIL rst_mid_pre: txd=%b state=%0d, required 0 %0d", txd0, st0, DATA);
        else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({txd0, busy0, if0.utx_fifo_rd_en_o} !== 3'b100 || st0 !== IDLE)
            $display("FAIL rst_mid_line: txd/busy/rd=%b state=%0d, required 100 %0d", {txd0, busy0, if0.utx_fifo_rd_en_o}, st0, IDLE);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        t = 0;
        while (rx_q0.size() == rxb && t < 80) begin
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (rx_q0.size() - rxb !== 1) $display("FAIL rst_mid_frames: got %0d, required 1", rx_q0.size() - rxb);
        else if (rx_q0[rxb] !== 8'h3C) $display("FAIL rst_mid_byte: got %h, required 3c", rx_q0[rxb]);
        else n_pass++;
        n_checks++;
        if (rd_cnt0 - rd_base !== 2 || empty0 !== 1'b1 || underrun0 !== 0)
            $display("FAIL rst_mid_pops: rd=%0d empty=%b underrun=%0d, required 2 1 0", rd_cnt0 - rd_base, empty0, underrun0);
        else n_pass++;
        en0 = 1'b0;

        // en dropped mid-frame: frame completes, no further pop
        rxb = rx_q0.size();
        rd_base = rd_cnt0;
        fifo_push(0, 8'h11);
        fifo_push(0, 8'h22);
        @(negedge clk);
        en0 = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!if0.utx_fifo_rd_en_o && t < 20);
        repeat (10) @(negedge clk);
        en0 = 1'b0;
        t = 0;
        while (rx_q0.size() == rxb && t < 80) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (rx_q0.size() - rxb !== 1) $display("FAIL en_drop_frames: got %0d, required 1", rx_q0.size() - rxb);
        else if (rx_q0[rxb] !== 8'h11) $display("FAIL en_drop_byte: got %h, required 11", rx_q0[rxb]);
        else n_pass++;
        repeat (100) @(negedge clk);
        n_checks++;
        if (rd_cnt0 - rd_base !== 1 || fq0.size() !== 1)
            $display("FAIL en_drop_pops: rd=%0d fifo_level=%0d, required 1 1", rd_cnt0 - rd_base, fq0.size());
        else n_pass++;
        n_checks++;
        if ({txd0, busy0} !== 2'b10) $display("FAIL en_drop_idle: txd/busy=%b, required 10", {txd0, busy0});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_empty_idle();
        test_back_to_back();
        test_parity();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog: reports and stops if the sequence ever stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end
endmodule
